axi_line_bridge: RTL and testbench

Responder for the cache's line-refill and line-writeback request interface; converts each accepted request into one AXI4 INCR burst. It sits between an I- or D-cache instance and the AXI interconnect, and each cache instantiates one. It terminates the cache-side handshake (req/rdy, then a one-cycle completion strobe). Read and write channels are independent and may be in flight simultaneously.

---
 rtl/axi_line_bridge_pkg.sv | 19 +
 rtl/axi_line_bridge.sv | 160 ++++++++++++++++
 tb/tb_axi_line_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_line_bridge_pkg.sv
// Shared types and address helpers for the cache line <-> AXI4 burst bridge.
package axi_line_bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} wr_state_t;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_LINE_WORD_NUM = 4;

    // Byte-offset bits inside one line; the cache derives its index split the same way.
    function automatic int offset_width(input int data_width, input int line_word_num);
        return $clog2(line_word_num * data_width / 8);
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int off);
        return addr & ~((32'd1 << off) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_line_bridge.sv
// Cache line refill/writeback responder: each accepted request becomes one AXI4 INCR burst.
// Read and write FSMs are fully independent and may run concurrently.
module axi_line_bridge
    import axi_line_bridge_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LINE_WORD_NUM = DEF_LINE_WORD_NUM
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rd_req,
    input  logic [31:0]                         rd_addr,
    output logic                                rd_rdy,
    output logic                                ret_valid,
    output logic [LINE_WORD_NUM*DATA_WIDTH-1:0] ret_data,
    input  logic                                wr_req,
    input  logic [31:0]                         wr_addr,
    input  logic [LINE_WORD_NUM*DATA_WIDTH-1:0] wr_data,
    output logic                                wr_rdy,
    output logic                                wr_valid,
    output logic [31:0]                         araddr,
    output logic [7:0]                          arlen,
    output logic                                arvalid,
    input  logic                                arready,
    input  logic [DATA_WIDTH-1:0]               rdata,
    input  logic                                rlast,
    input  logic                                rvalid,
    output logic                                rready,
    output logic [31:0]                         awaddr,
    output logic [7:0]                          awlen,
    output logic                                awvalid,
    input  logic                                awready,
    output logic [DATA_WIDTH-1:0]               wdata,
    output logic                                wlast,
    output logic                                wvalid,
    input  logic                                wready,
    input  logic                                bvalid,
    output logic                                bready
);

    localparam int              OFFSET_WIDTH = offset_width(DATA_WIDTH, LINE_WORD_NUM);
    localparam int              CW           = $clog2(LINE_WORD_NUM);
    localparam logic [CW-1:0]   CNT_LAST     = CW'(LINE_WORD_NUM - 1);
    localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
    localparam logic [7:0]      BURST_LEN    = 8'(LINE_WORD_NUM - 1);

    typedef logic [LINE_WORD_NUM-1:0][DATA_WIDTH-1:0] line_t;

    rd_state_t       rstate_q, rstate_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [31:0]     raddr_q, raddr_d;
    line_t           rline_q, rline_d;

    wr_state_t       wstate_q, wstate_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [31:0]     waddr_q, waddr_d;
    line_t           wline_q, wline_d;

    // Burst length is fixed, so rlast carries no information the beat counter lacks.
    logic unused_rlast;
    assign unused_rlast = rlast;

    // ---------------- read channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            raddr_q  <= '0;
            rline_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            raddr_q  <= raddr_d;
            rline_q  <= rline_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        raddr_d  = raddr_q;
        rline_d  = rline_q;
        case (rstate_q)
            R_IDLE: if (rd_req) begin
                raddr_d  = line_align(rd_addr, OFFSET_WIDTH);
                rstate_d = R_AR;
            end
            R_AR:   if (arready) rstate_d = R_DATA;
            R_DATA: if (rvalid) begin
                rline_d[rcnt_q] = rdata;
                rcnt_d          = rcnt_q + CNT_ONE;
                if (rcnt_q == CNT_LAST) rstate_d = R_DONE;
            end
            R_DONE: rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_rdy    = (rstate_q == R_IDLE);
        arvalid   = (rstate_q == R_AR);
        rready    = (rstate_q == R_DATA);
        ret_valid = (rstate_q == R_DONE);
    end

    assign araddr   = raddr_q;
    assign arlen    = BURST_LEN;
    assign ret_data = rline_q;

    // ---------------- write channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= '0;
            waddr_q  <= '0;
            wline_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            waddr_q  <= waddr_d;
            wline_q  <= wline_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        waddr_d  = waddr_q;
        wline_d  = wline_q;
        case (wstate_q)
            W_IDLE: if (wr_req) begin
                waddr_d  = line_align(wr_addr, OFFSET_WIDTH);
                wline_d  = wr_data;
                wstate_d = W_AW;
            end
            W_AW:   if (awready) wstate_d = W_DATA;
            W_DATA: if (wready) begin
                wcnt_d = wcnt_q + CNT_ONE;
                if (wcnt_q == CNT_LAST) wstate_d = W_RESP;
            end
            W_RESP: if (bvalid) wstate_d = W_DONE;
            W_DONE: wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        wr_rdy   = (wstate_q == W_IDLE);
        awvalid  = (wstate_q == W_AW);
        wvalid   = (wstate_q == W_DATA);
        wlast    = (wstate_q == W_DATA) && (wcnt_q == CNT_LAST);
        bready   = (wstate_q == W_RESP);
        wr_valid = (wstate_q == W_DONE);
    end

    assign awaddr = waddr_q;
    assign awlen  = BURST_LEN;
    assign wdata  = wline_q[wcnt_q];

endmodule

// File: tb/tb_axi_line_bridge.sv
// Scoreboard bench for axi_line_bridge: randomized AXI responders plus a line-level reference.
module tb_axi_line_bridge;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int LW = N * DW;
    localparam int LB = N * DW / 8;

    typedef logic [LW-1:0] line_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req, rd_rdy, ret_valid;
    logic [31:0]   rd_addr;
    line_t         ret_data;
    logic          wr_req, wr_rdy, wr_valid;
    logic [31:0]   wr_addr;
    line_t         wr_data;
    logic [31:0]   araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] rdata, wdata;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_line_bridge #(.DATA_WIDTH(DW), .LINE_WORD_NUM(N)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .wr_valid(wr_valid),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected traffic, pushed by the request drivers and AXI responders.
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_aw_q[$];
    line_t       rburst_q[$];
    line_t       ret_q[$];
    line_t       wr_exp_q[$];

    int  ridx = 0, widx = 0;
    bit  b_pend = 0;
    int  wresp_cnt = 0, b_hs_cyc = 0;
    int  ar_pct = 100, r_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
    int  w_stall_beat = -1, w_stall_left = 0;
    bit  fixed_data = 0, lat_armed = 0;
    int  rd_acc_cyc = 0, wr_acc_cyc = 0;
    int  ret_cnt = 0, wrv_cnt = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < N; i++) l[i*DW +: DW] = $urandom;
        return l;
    endfunction

    // ---------------- AXI read responder ----------------
    initial begin : rslave
        line_t cur, nl;
        arready = 0; rvalid = 0; rdata = '0; rlast = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; ridx = 0;
                rburst_q.delete();
                continue;
            end
            if (rburst_q.size() > 0) begin
                cur    = rburst_q[0];
                rvalid = pct(r_pct);
                rdata  = cur[ridx*DW +: DW];
                rlast  = (ridx == N - 1);
                if (rvalid && rready) begin
                    ridx++;
                    if (ridx == N) begin
                        ret_q.push_back(rburst_q.pop_front());
                        ridx = 0;
                    end
                end
            end else begin
                rvalid = 0; rlast = 0;
            end
            arready = pct(ar_pct);
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) fail_evt("araddr", "AR handshake with no outstanding read");
                else chk("araddr", araddr, exp_ar_q.pop_front());
                chk("arlen", arlen, N - 1);
                for (int i = 0; i < N; i++)
                    nl[i*DW +: DW] = fixed_data ? 32'hA0 + i : $urandom;
                rburst_q.push_back(nl);
            end
        end
    end

    // ---------------- AXI write responder ----------------
    initial begin : wslave
        line_t wline;
        awready = 0; wready = 0; bvalid = 0;
        wline = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; widx = 0; b_pend = 0;
                continue;
            end
            if (b_pend) begin
                bvalid = pct(b_pct);
                if (bvalid && bready) begin
                    b_pend = 0;
                    wresp_cnt++;
                    b_hs_cyc = cyc;
                end
            end else bvalid = 0;
            if (wvalid && widx == w_stall_beat && w_stall_left > 0) begin
                wready = 0;
                w_stall_left--;
            end else wready = pct(w_pct);
            if (wvalid && wready) begin
                wline[widx*DW +: DW] = wdata;
                chk("wlast", wlast, widx == N - 1);
                widx++;
                if (widx == N) begin
                    widx   = 0;
                    b_pend = 1;
                    if (wr_exp_q.size() == 0) fail_evt("wr_line", "W burst with no outstanding write");
                    else chk("wr_line", wline, wr_exp_q.pop_front());
                end
            end
            awready = pct(aw_pct);
            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) fail_evt("awaddr", "AW handshake with no outstanding write");
                else chk("awaddr", awaddr, exp_aw_q.pop_front());
                chk("awlen", awlen, N - 1);
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin : monitor
        bit p_ar = 0, p_aw = 0, p_w = 0, p_rd = 0, p_wr = 0, p_wlast = 0;
        logic [31:0] p_araddr = '0, p_awaddr = '0;
        logic [DW-1:0] p_wdata = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                p_ar = 0; p_aw = 0; p_w = 0; p_rd = 0; p_wr = 0;
                continue;
            end
            if (ret_valid) begin
                ret_cnt++;
                if (ret_q.size() == 0) fail_evt("ret_valid", "pulse with no completed read burst");
                else chk("ret_data", ret_data, ret_q.pop_front());
                if (lat_armed) begin
                    chk("rd_latency", cyc - rd_acc_cyc, N + 2);
                    lat_armed = 0;
                end
            end
            if (wr_valid) begin
                wrv_cnt++;
                if (wresp_cnt == 0) fail_evt("wr_valid", "pulse with no B handshake");
                else begin
                    wresp_cnt--;
                    chk("wr_valid_timing", cyc, b_hs_cyc + 1);
                end
            end
            if (p_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (p_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_w)  chk("w_hold", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
            if (p_rd) chk("rd_rdy_drop", rd_rdy, 1'b0);
            if (p_wr) chk("wr_rdy_drop", wr_rdy, 1'b0);
            p_ar = arvalid && !arready; p_araddr = araddr;
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata = wdata; p_wlast = wlast;
            p_rd = rd_req && rd_rdy;
            p_wr = wr_req && wr_rdy;
        end
    end

    // ---------------- request drivers ----------------
    task automatic issue_read(input logic [31:0] a);
        int t = 0;
        @(negedge clk);
        rd_req = 1; rd_addr = a;
        while (!rd_rdy && t < 500) begin @(negedge clk); t++; end
        if (!rd_rdy) fail_evt("rd_accept", "rd_rdy never asserted");
        else begin
            exp_ar_q.push_back((a / LB) * LB);
            rd_acc_cyc = cyc;
        end
        @(negedge clk);
        rd_req = 0; rd_addr = $urandom;
    endtask

    task automatic issue_write(input logic [31:0] a, input line_t l);
        int t = 0;
        @(negedge clk);
        wr_req = 1; wr_addr = a; wr_data = l;
        while (!wr_rdy && t < 500) begin @(negedge clk); t++; end
        if (!wr_rdy) fail_evt("wr_accept", "wr_rdy never asserted");
        else begin
            exp_aw_q.push_back((a / LB) * LB);
            wr_exp_q.push_back(l);
            wr_acc_cyc = cyc;
        end
        @(negedge clk);
        wr_req = 0; wr_addr = $urandom; wr_data = rand_line();
    endtask

    function automatic bit all_idle();
        return exp_ar_q.size() == 0 && rburst_q.size() == 0 && ret_q.size() == 0 &&
               exp_aw_q.size() == 0 && wr_exp_q.size() == 0 && !b_pend &&
               wresp_cnt == 0 && rd_rdy && wr_rdy;
    endfunction

    task automatic wait_idle(input string nm);
        int t = 0;
        while (t < 3000 && !all_idle()) begin @(negedge clk); #2; t++; end
        if (!all_idle()) fail_evt(nm, "traffic did not drain within cycle budget");
    endtask

    // Called at negedge+2; asserts reset mid-cycle and checks the async clear.
    task automatic do_reset();
        #1 rst = 1;
        exp_ar_q.delete(); exp_aw_q.delete(); ret_q.delete(); wr_exp_q.delete();
        rburst_q.delete();
        wresp_cnt = 0; lat_armed = 0;
        #1;
        chk("rst_rdy", {rd_rdy, wr_rdy}, 2'b11);
        chk("rst_valids", {arvalid, rready, ret_valid, awvalid, wvalid, wlast, bready, wr_valid}, 8'h00);
        chk("rst_ret_data", ret_data, '0);
        chk("rst_addrs", {araddr, awaddr}, 64'h0);
        repeat (2) @(negedge clk);
        #3 rst = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int r0, w0, t;
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
        @(negedge clk); #2;
        do_reset();

        // Directed read: fixed beats, all readies high, latency checked.
        fixed_data = 1; lat_armed = 1;
        issue_read(32'h1FC0_1234);
        wait_idle("t1_drain");
        fixed_data = 0;
        chk("t1_ret_data", ret_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_araddr", araddr, 32'h1FC0_1230);

        // Directed write with a 3-cycle wready stall on the second beat.
        w_stall_beat = 1; w_stall_left = 3;
        issue_write(32'h8000_0048, 128'h00000004_00000003_00000002_00000001);
        wait_idle("t2_drain");
        w_stall_beat = -1;
        chk("t2_awaddr", awaddr, 32'h8000_0040);

        // Simultaneous read and write acceptance.
        r0 = ret_cnt; w0 = wrv_cnt;
        fork
            issue_read($urandom);
            issue_write($urandom, rand_line());
        join
        chk("t3_same_cycle", rd_acc_cyc, wr_acc_cyc);
        wait_idle("t3_drain");
        chk("t3_pulses", {ret_cnt - r0, wrv_cnt - w0}, {32'd1, 32'd1});

        // Delayed arready plus gappy R beats.
        ar_pct = 0; r_pct = 50;
        issue_read($urandom);
        repeat (5) @(negedge clk);
        ar_pct = 100;
        wait_idle("t4_drain");
        r_pct = 100;

        // Reset in the middle of the R data phase, then a clean read.
        issue_read($urandom);
        t = 0;
        while (ridx != 2 && t < 100) begin @(negedge clk); #2; t++; end
        if (ridx != 2) fail_evt("t5_beat2", "read burst never reached beat 2");
        do_reset();
        r0 = ret_cnt;
        issue_read($urandom);
        wait_idle("t5_drain");
        chk("t5_one_pulse", ret_cnt - r0, 1);

        // Randomized concurrent traffic with random backpressure.
        ar_pct = $urandom_range(30, 100); r_pct = $urandom_range(30, 100);
        aw_pct = $urandom_range(30, 100); w_pct = $urandom_range(30, 100);
        b_pct  = $urandom_range(30, 100);
        fork
            begin
                repeat (15) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    issue_read($urandom);
                end
            end
            begin
                repeat (15) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    issue_write($urandom, rand_line());
                end
            end
        join
        wait_idle("rand_drain");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
